mmu_load_ctrl: RTL and testbench

- Sits directly upstream of the MMU feeder.
- Accepts a byte stream from the host pins and captures four weights and four inputs into holding registers.
- Once the operands are loaded, sequences a compute run by driving `en` and the `mmu_cycles` counter that the feeder decodes.
- Supports weight reuse: a new run can reload only the four inputs.

---
 rtl/mmu_load_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mmu_load_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_load_ctrl.sv
// Purpose: captures 4 weights + 4 inputs from a host byte stream, then sequences an MMU feeder run.
// Latency: run (en=1, mmu_cycles=0) starts on the edge accepting the last byte; done pulses 1 cycle after mmu_cycles==RUN_LAST.
// Backpressure: in_ready low during RUN, during abort and while rst is asserted; bytes are taken on in_valid && in_ready.
module mmu_load_ctrl #(
  parameter int DATA_W   = 8,
  parameter int RUN_LAST = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              keep_weights,
  input  logic              abort,
  output logic [DATA_W-1:0] weight_0,
  output logic [DATA_W-1:0] weight_1,
  output logic [DATA_W-1:0] weight_2,
  output logic [DATA_W-1:0] weight_3,
  output logic [DATA_W-1:0] input_0,
  output logic [DATA_W-1:0] input_1,
  output logic [DATA_W-1:0] input_2,
  output logic [DATA_W-1:0] input_3,
  output logic              en,
  output logic [2:0]        mmu_cycles,
  output logic              weights_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [2:0] CYC_LAST = 3'(RUN_LAST);

  state_t            state_q, state_nxt;
  logic [2:0]        idx_q, idx_nxt;
  logic              en_q, en_nxt;
  logic [2:0]        cyc_q, cyc_nxt;
  logic              wv_q, wv_nxt;
  logic              done_q, done_nxt;
  logic              wr_en;
  logic [2:0]        wr_slot;
  logic              accept;
  logic [DATA_W-1:0] ops_q [8];

  // Handshake: nothing is accepted while cancelling or while reset is held.
  always_comb begin
    in_ready = (state_q == IDLE || state_q == LOAD) && !abort && !rst;
    accept   = in_valid && in_ready;
  end

  // Next-state, slot write selection and run sequencing; abort overrides everything.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    en_nxt    = en_q;
    cyc_nxt   = cyc_q;
    wv_nxt    = wv_q;
    done_nxt  = 1'b0;
    wr_en     = 1'b0;
    wr_slot   = idx_q;
    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = 3'd0;
      en_nxt    = 1'b0;
      cyc_nxt   = 3'd0;
      wv_nxt    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            wr_en     = 1'b1;
            state_nxt = LOAD;
            if (keep_weights && wv_q) begin
              // Weight reuse: skip straight to the input slots.
              wr_slot = 3'd4;
              idx_nxt = 3'd5;
            end else begin
              // A fresh weight set invalidates the old one immediately.
              wr_slot = 3'd0;
              idx_nxt = 3'd1;
              wv_nxt  = 1'b0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_en   = 1'b1;
            wr_slot = idx_q;
            idx_nxt = idx_q + 3'd1;
            if (idx_q == 3'd3) wv_nxt = 1'b1;
            if (idx_q == 3'd7) begin
              state_nxt = RUN;
              idx_nxt   = 3'd0;
              en_nxt    = 1'b1;
              cyc_nxt   = 3'd0;
            end
          end
        end
        RUN: begin
          if (cyc_q == CYC_LAST) begin
            state_nxt = IDLE;
            en_nxt    = 1'b0;
            cyc_nxt   = 3'd0;
            done_nxt  = 1'b1;
          end else begin
            cyc_nxt = cyc_q + 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
          en_nxt    = 1'b0;
          cyc_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      en_q    <= 1'b0;
      cyc_q   <= 3'd0;
      wv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      en_q    <= en_nxt;
      cyc_q   <= cyc_nxt;
      wv_q    <= wv_nxt;
      done_q  <= done_nxt;
    end
  end

  // Operand holding registers; untouched by abort so a partial set stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) ops_q[i] <= '0;
    end else if (wr_en) begin
      ops_q[wr_slot] <= in_data;
    end
  end

  assign weight_0      = ops_q[0];
  assign weight_1      = ops_q[1];
  assign weight_2      = ops_q[2];
  assign weight_3      = ops_q[3];
  assign input_0       = ops_q[4];
  assign input_1       = ops_q[5];
  assign input_2       = ops_q[6];
  assign input_3       = ops_q[7];
  assign en            = en_q;
  assign mmu_cycles    = cyc_q;
  assign weights_valid = wv_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mmu_load_ctrl.sv
// Purpose: directed-vector bench for mmu_load_ctrl with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: exercises bubbles, bytes offered during RUN and abort.
module tb_mmu_load_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       keep_weights;
  logic       abort;
  logic [7:0] weight_0, weight_1, weight_2, weight_3;
  logic [7:0] input_0, input_1, input_2, input_3;
  logic       en;
  logic [2:0] mmu_cycles;
  logic       weights_valid;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  mmu_load_ctrl #(.DATA_W(8), .RUN_LAST(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .keep_weights  (keep_weights),
    .abort         (abort),
    .weight_0      (weight_0),
    .weight_1      (weight_1),
    .weight_2      (weight_2),
    .weight_3      (weight_3),
    .input_0       (input_0),
    .input_1       (input_1),
    .input_2       (input_2),
    .input_3       (input_3),
    .en            (en),
    .mmu_cycles    (mmu_cycles),
    .weights_valid (weights_valid),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_ops(input string tag,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3,
                           input logic [7:0] i0, input logic [7:0] i1,
                           input logic [7:0] i2, input logic [7:0] i3);
    check({tag, ".w0"}, {24'd0, weight_0}, {24'd0, w0});
    check({tag, ".w1"}, {24'd0, weight_1}, {24'd0, w1});
    check({tag, ".w2"}, {24'd0, weight_2}, {24'd0, w2});
    check({tag, ".w3"}, {24'd0, weight_3}, {24'd0, w3});
    check({tag, ".i0"}, {24'd0, input_0},  {24'd0, i0});
    check({tag, ".i1"}, {24'd0, input_1},  {24'd0, i1});
    check({tag, ".i2"}, {24'd0, input_2},  {24'd0, i2});
    check({tag, ".i3"}, {24'd0, input_3},  {24'd0, i3});
  endtask

  // Called in the first RUN cycle; walks mmu_cycles 0..6 and checks the done pulse.
  task automatic run_through(input string tag, input logic offer);
    for (int k = 0; k < 7; k++) begin
      check({tag, ".en"},  {31'd0, en}, 32'd1);
      check({tag, ".cyc"}, {29'd0, mmu_cycles}, k);
      check({tag, ".rdy"}, {31'd0, in_ready}, 32'd0);
      in_valid = offer && (k < 6);
      in_data  = 8'hEE;
      tick();
    end
    in_valid = 1'b0;
    check({tag, ".done"},    {31'd0, done}, 32'd1);
    check({tag, ".en_off"},  {31'd0, en}, 32'd0);
    check({tag, ".cyc_off"}, {29'd0, mmu_cycles}, 32'd0);
    check({tag, ".rdy_on"},  {31'd0, in_ready}, 32'd1);
    tick();
    check({tag, ".done_1"},  {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_data = 8'd0;
    in_valid = 1'b0;
    keep_weights = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst.rdy",  {31'd0, in_ready}, 32'd0);
    check("rst.en",   {31'd0, en}, 32'd0);
    check("rst.cyc",  {29'd0, mmu_cycles}, 32'd0);
    check("rst.wv",   {31'd0, weights_valid}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check_ops("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("rel.rdy", {31'd0, in_ready}, 32'd1);
    tick();

    // Full load 1..8 back to back
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i));
      if (i == 3) check("full.wv3", {31'd0, weights_valid}, 32'd0);
      if (i == 4) check("full.wv4", {31'd0, weights_valid}, 32'd1);
      if (i == 7) check("full.en7", {31'd0, en}, 32'd0);
    end
    check("full.busy", {31'd0, busy}, 32'd1);
    check_ops("full", 1, 2, 3, 4, 5, 6, 7, 8);
    run_through("full", 1'b0);

    // Weight reuse: only 4 input bytes
    keep_weights = 1'b1;
    send_byte(8'd9);
    keep_weights = 1'b0;
    check("reuse.wv", {31'd0, weights_valid}, 32'd1);
    send_byte(8'd10);
    send_byte(8'd11);
    check("reuse.en3", {31'd0, en}, 32'd0);
    send_byte(8'd12);
    check("reuse.wv_end", {31'd0, weights_valid}, 32'd1);
    check_ops("reuse", 1, 2, 3, 4, 9, 10, 11, 12);
    run_through("reuse", 1'b0);

    // Bubbles between bytes, then bytes offered during RUN
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b0;
      tick();
      send_byte(8'(i));
      if (i == 1) check("bub.wv_clr", {31'd0, weights_valid}, 32'd0);
    end
    check_ops("bub", 1, 2, 3, 4, 5, 6, 7, 8);
    run_through("bub", 1'b1);
    check_ops("bub.post", 1, 2, 3, 4, 5, 6, 7, 8);

    // Abort after 5 bytes, byte offered in abort cycle is dropped
    for (int i = 0; i < 5; i++) send_byte(8'h21 + 8'(i));
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    #1;
    check("ab.rdy", {31'd0, in_ready}, 32'd0);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check("ab.busy", {31'd0, busy}, 32'd0);
    check("ab.wv",   {31'd0, weights_valid}, 32'd0);
    check("ab.en",   {31'd0, en}, 32'd0);
    check_ops("ab", 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 6, 7, 8);

    // keep_weights without valid weights forces a full load
    keep_weights = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h31 + 8'(i));
      if (i == 3) begin
        check("kw.en4",   {31'd0, en}, 32'd0);
        check("kw.busy4", {31'd0, busy}, 32'd1);
      end
    end
    keep_weights = 1'b0;
    check("kw.en", {31'd0, en}, 32'd1);
    check_ops("kw", 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38);

    // Abort at mmu_cycles==3
    tick();
    tick();
    tick();
    check("abr.cyc3", {29'd0, mmu_cycles}, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abr.en",   {31'd0, en}, 32'd0);
    check("abr.cyc",  {29'd0, mmu_cycles}, 32'd0);
    check("abr.done", {31'd0, done}, 32'd0);
    check("abr.busy", {31'd0, busy}, 32'd0);
    tick();
    check("abr.done1", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-RUN
    for (int i = 0; i < 8; i++) send_byte(8'h41 + 8'(i));
    tick();
    tick();
    check("ar.pre_cyc", {29'd0, mmu_cycles}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("ar.en",   {31'd0, en}, 32'd0);
    check("ar.cyc",  {29'd0, mmu_cycles}, 32'd0);
    check("ar.wv",   {31'd0, weights_valid}, 32'd0);
    check("ar.done", {31'd0, done}, 32'd0);
    check("ar.rdy",  {31'd0, in_ready}, 32'd0);
    check_ops("ar", 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    tick();
    check("ar.rdy_rel", {31'd0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
